// File: rtl/stack_sequencer_if.sv
// Data-memory port shared by the stack sequencer: single outstanding request,
// held stable until the memory acknowledges it.
interface stack_sequencer_if;
    // mem_req rises with mem_addr/mem_wdata/mem_we already stable; all hold until
    // the cycle mem_ack=1, which also marks mem_rdata valid; the request then drops.
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/stack_sequencer.sv
// Multicycle PUSH/POP/CALL/RET sequencer: owns the stack pointer, checks bounds,
// performs one data-memory access per operation and raises writeback/PC strobes.
module stack_sequencer #(
    parameter logic [31:0] SP_INIT  = 32'd1024,
    parameter logic [31:0] SP_LIMIT = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    input  logic [31:0] target,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] sp,
    output logic [31:0] rdata,
    output logic        reg_we,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic [2:0]  fsm_state,
    stack_sequencer_if.master mem
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] wdata_q;
    logic [31:0] target_q;

    logic is_push;
    logic is_pop;
    logic is_call;
    logic is_ret;
    logic is_write;
    logic is_read;
    logic bad_op;

    assign is_push  = (op_q == OP_PUSH);
    assign is_pop   = (op_q == OP_POP);
    assign is_call  = (op_q == OP_CALL);
    assign is_ret   = (op_q == OP_RET);
    assign is_write = is_push | is_call;
    assign is_read  = is_pop | is_ret;
    // Overflow/underflow fold into the same error path as an illegal opcode.
    assign bad_op   = !(is_write || is_read)
                    || (is_write && (sp == SP_LIMIT))
                    || (is_read  && (sp == SP_INIT));

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            op_q          <= 3'd0;
            wdata_q       <= 32'd0;
            target_q      <= 32'd0;
            sp            <= SP_INIT;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= 32'd0;
            reg_we        <= 1'b0;
            pc_load       <= 1'b0;
            pc_next       <= 32'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            reg_we  <= 1'b0;
            pc_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        wdata_q  <= wdata;
                        target_q <= target;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bad_op) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        // SP points at the last pushed word, so writes go one below it.
                        mem.mem_addr  <= is_write ? (sp - 32'd1) : sp;
                        mem.mem_wdata <= wdata_q;
                        mem.mem_we    <= is_write;
                        mem.mem_req   <= 1'b1;
                        state         <= MEM;
                    end
                end
                MEM: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if (is_read) begin
                            rdata <= mem.mem_rdata;
                        end
                        if (is_call) begin
                            pc_next <= target_q;
                        end else if (is_ret) begin
                            pc_next <= mem.mem_rdata;
                        end
                        pc_load <= is_call | is_ret;
                        reg_we  <= is_pop;
                        done    <= 1'b1;
                        state   <= WB;
                    end
                end
                WB: begin
                    sp    <= is_write ? (sp - 32'd1) : (sp + 32'd1);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a stack model (exp_q) stands in for the
// data memory, and a second instance with a two-word stack covers overflow.
module tb_stack_sequencer;

    localparam logic [31:0] SP_INIT  = 32'd1024;
    localparam logic [2:0]  OP_PUSH  = 3'b001;
    localparam logic [2:0]  OP_POP   = 3'b010;
    localparam logic [2:0]  OP_CALL  = 3'b011;
    localparam logic [2:0]  OP_RET   = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] target = 32'd0;
    logic        busy, done, err, reg_we, pc_load;
    logic [31:0] sp, rdata, pc_next;
    logic [2:0]  state1;

    logic        start2 = 1'b0;
    logic [2:0]  op2 = 3'b001;
    logic [31:0] wdata2 = 32'h1234_5678;
    logic [31:0] target2 = 32'd0;
    logic        busy2, done2, err2, reg_we2, pc_load2;
    logic [31:0] sp2, rdata2, pc_next2;
    logic [2:0]  state2;

    stack_sequencer_if m1 ();
    stack_sequencer_if m2 ();

    stack_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .wdata(wdata), .target(target),
        .busy(busy), .done(done), .err(err), .sp(sp), .rdata(rdata),
        .reg_we(reg_we), .pc_load(pc_load), .pc_next(pc_next),
        .fsm_state(state1), .mem(m1.master)
    );

    stack_sequencer #(.SP_INIT(32'd2), .SP_LIMIT(32'd0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .wdata(wdata2), .target(target2),
        .busy(busy2), .done(done2), .err(err2), .sp(sp2), .rdata(rdata2),
        .reg_we(reg_we2), .pc_load(pc_load2), .pc_next(pc_next2),
        .fsm_state(state2), .mem(m2.master)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_sp = SP_INIT;
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] exp_pc = 32'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation on dut, answering the memory after 'waits' stall cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] wd, input logic [31:0] tg,
                          input int waits, input bit poke);
        bit          is_wr;
        bit          is_rd;
        bit          exp_err;
        logic [31:0] addr;
        logic [31:0] word;
        is_wr   = (o == OP_PUSH) || (o == OP_CALL);
        is_rd   = (o == OP_POP) || (o == OP_RET);
        exp_err = !(is_wr || is_rd) || (is_wr && exp_sp == 32'd0) || (is_rd && exp_sp == SP_INIT);
        start = 1'b1; op = o; wdata = wd; target = tg;
        tick();
        start = 1'b0;
        check("addr_busy", 32'(busy), 32'd1);
        check("addr_done", 32'(done), 32'd0);
        tick();
        if (exp_err) begin
            check("err_done", 32'(done), 32'd1);
            check("err_flag", 32'(err), 32'd1);
            check("err_noreq", 32'(m1.mem_req), 32'd0);
            check("err_pc_load", 32'(pc_load), 32'd0);
            tick();
            check("err_end_done", 32'(done), 32'd0);
            check("err_end_busy", 32'(busy), 32'd0);
            check("err_sp", sp, exp_sp);
            return;
        end
        addr = is_wr ? exp_sp - 32'd1 : exp_sp;
        check("mem_req", 32'(m1.mem_req), 32'd1);
        check("mem_addr", m1.mem_addr, addr);
        check("mem_we", 32'(m1.mem_we), 32'(is_wr));
        if (is_wr) check("mem_wdata", m1.mem_wdata, wd);
        for (int i = 0; i < waits; i++) begin
            if (poke && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            check("wait_req", 32'(m1.mem_req), 32'd1);
            check("wait_done", 32'(done), 32'd0);
        end
        word = is_wr ? wd : exp_q[0];
        m1.mem_ack = 1'b1;
        m1.mem_rdata = is_wr ? 32'hBAD0_BAD0 : word;
        tick();
        m1.mem_ack = 1'b0;
        if (is_wr) begin
            exp_q.push_front(wd);
            exp_sp = exp_sp - 32'd1;
        end else begin
            exp_rdata = exp_q.pop_front();
            exp_sp = exp_sp + 32'd1;
        end
        if (o == OP_CALL) exp_pc = tg;
        if (o == OP_RET) exp_pc = word;
        check("wb_done", 32'(done), 32'd1);
        check("wb_err", 32'(err), 32'd0);
        check("wb_req", 32'(m1.mem_req), 32'd0);
        check("wb_reg_we", 32'(reg_we), 32'(o == OP_POP));
        check("wb_pc_load", 32'(pc_load), 32'(o == OP_CALL || o == OP_RET));
        check("wb_pc_next", pc_next, exp_pc);
        check("wb_rdata", rdata, exp_rdata);
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_reg_we", 32'(reg_we), 32'd0);
        check("post_pc_load", 32'(pc_load), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_sp", sp, exp_sp);
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("poke_no_done", 32'(done), 32'd0);
                check("poke_idle", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic push2(input bit exp_err, input logic [31:0] sp_after);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        if (exp_err) begin
            check("d2_err_done", 32'(done2), 32'd1);
            check("d2_err_flag", 32'(err2), 32'd1);
            check("d2_err_noreq", 32'(m2.mem_req), 32'd0);
            tick();
        end else begin
            check("d2_req", 32'(m2.mem_req), 32'd1);
            check("d2_addr", m2.mem_addr, sp_after);
            check("d2_wdata", m2.mem_wdata, wdata2);
            check("d2_we", 32'(m2.mem_we), 32'd1);
            m2.mem_ack = 1'b1;
            tick();
            m2.mem_ack = 1'b0;
            check("d2_done", 32'(done2), 32'd1);
            check("d2_err", 32'(err2), 32'd0);
            check("d2_reg_we", 32'(reg_we2), 32'd0);
            check("d2_pc_load", 32'(pc_load2), 32'd0);
            tick();
        end
        check("d2_sp", sp2, sp_after);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m1.mem_ack = 1'b0; m1.mem_rdata = 32'd0;
        m2.mem_ack = 1'b0; m2.mem_rdata = 32'd0;
        tick();
        tick();
        check("rst_sp", sp, SP_INIT);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(m1.mem_req), 32'd0);
        check("rst_pc_next", pc_next, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_state", 32'(state1), 32'd0);
        check("rst_state2", 32'(state2), 32'd0);
        check("rst_sp2", sp2, 32'd2);
        rst = 1'b1;
        tick();

        // Reset lands while the request is outstanding and must abandon it.
        start = 1'b1; op = OP_PUSH; wdata = 32'h5555_AAAA;
        tick();
        start = 1'b0;
        tick();
        check("mid_req_before", 32'(m1.mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_req", 32'(m1.mem_req), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_sp", sp, SP_INIT);
        check("mid_we", 32'(m1.mem_we), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_done", 32'(done), 32'd0);
            check("mid_sp_hold", sp, SP_INIT);
        end

        run_op(OP_PUSH, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        run_op(OP_POP,  32'd0, 32'd0, 2, 1'b0);
        run_op(OP_CALL, 32'h0000_0040, 32'h0000_0100, 0, 1'b0);
        run_op(OP_RET,  32'd0, 32'd0, 1, 1'b0);
        run_op(OP_POP,  32'd0, 32'd0, 0, 1'b0);
        run_op(3'b000,  32'd0, 32'd0, 0, 1'b0);
        run_op(3'b101,  32'd0, 32'd0, 0, 1'b0);
        run_op(3'b111,  32'd0, 32'd0, 0, 1'b0);
        run_op(OP_PUSH, 32'h0BAD_F00D, 32'd0, 3, 1'b1);
        run_op(OP_PUSH, 32'h1111_2222, 32'd0, 0, 1'b0);
        run_op(OP_POP,  32'd0, 32'd0, 1, 1'b0);
        run_op(OP_POP,  32'd0, 32'd0, 0, 1'b0);

        push2(1'b0, 32'd1);
        push2(1'b0, 32'd0);
        push2(1'b1, 32'd0);
        check("d2_rdata_untouched", rdata2, 32'd0);
        check("d2_pc_next_untouched", pc_next2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multicycle sequencer for the stack datapath of the RISC core. It accepts one stack instruction (PUSH, POP, CALL, RET) from the main control unit, then runs it through three phases: address generation, a single data-memory access, and writeback. It owns the architectural stack pointer and checks stack bounds. It drives the shared data-memory port with a req/ack handshake and produces the register-writeback and PC-load strobes.

## Interface
- SP_INIT, 1024: SP value after reset; the stack is empty when SP == SP_INIT. The stack grows downward and SP points at the last pushed word.
- SP_LIMIT, 0: lowest legal stack address; the stack is full when SP == SP_LIMIT.
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  request a stack operation; sampled only in IDLE
- op  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET; all other codes are illegal
- wdata  in  32  PUSH: register value; CALL: return address (NPC)
- target  in  32  CALL branch target
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = overflow, underflow or illegal op
- sp  out  32  current stack pointer
- rdata  out  32  word read by POP/RET
- reg_we  out  1  one-cycle pulse with done on a successful POP
- pc_load  out  1  one-cycle pulse with done on a successful CALL or RET
- pc_next  out  32  CALL: target; RET: popped word
- mem_req, mem_we  out  1  memory request; write enable (PUSH/CALL)
- mem_addr, mem_wdata  out  32  memory address; write data
- mem_ack  in  1  memory accepted the request (and read data is valid)
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE, ADDR, MEM, WB, ERR.
- IDLE:
  - start=1: latch op, wdata and target, then go to ADDR.
  - start=0: stay in IDLE.
- ADDR:
  - Illegal op → ERR.
  - PUSH/CALL with sp == SP_LIMIT → ERR (overflow).
  - POP/RET with sp == SP_INIT → ERR (underflow).
  - Otherwise register mem_addr (sp−1 for PUSH/CALL, sp for POP/RET), mem_wdata and mem_we, then go to MEM.
- MEM:
  - mem_req=1; mem_addr, mem_wdata and mem_we are held stable.
  - On mem_ack=1: capture mem_rdata into rdata (POP/RET only) and go to WB.
  - Wait indefinitely until mem_ack arrives.
- WB:
  - done=1, err=0.
  - sp ← sp−1 (PUSH/CALL) or sp+1 (POP/RET).
  - POP: reg_we=1.
  - CALL: pc_load=1, pc_next=target.
  - RET: pc_load=1, pc_next=rdata.
  - Go to IDLE.
- ERR: done=1, err=1; sp, memory and PC are untouched; go to IDLE.
- SP arithmetic is 32-bit modulo 2^32. The bounds checks guarantee it never wraps in practice.
- mem_ack outside MEM is ignored. start outside IDLE is ignored; it is neither queued nor errored.
- Only one operation is ever outstanding.

## Timing
- Reset (rst=0) takes effect immediately, without waiting for clk:
  - State goes to IDLE; sp=SP_INIT.
  - busy, done, err, reg_we, pc_load, mem_req and mem_we = 0.
  - mem_addr, mem_wdata, rdata and pc_next = 0.
- Reset in the middle of an operation abandons it: mem_req drops at once and no writeback or SP update occurs.
- Cycle numbering, with start sampled at edge 0:
  - Cycle 1: ADDR.
  - Cycle 2: MEM, with mem_req high.
  - With mem_ack in the first MEM cycle, WB and done fall in cycle 3. Each wait cycle adds one.
  - Error path: ERR, with done and err, falls in cycle 2, and mem_req is never raised.
- New sp is visible the cycle after WB. A start presented in that cycle sees the updated sp.
- Maximum throughput is one operation per 4 cycles: a start may be accepted in the cycle after done.
- done, reg_we and pc_load are each exactly one cycle wide.
- rdata and pc_next hold their values until the next WB.

## Test plan
- Reset: assert rst=0 while in MEM with mem_req=1 → same cycle: mem_req=0, busy=0, sp=1024; no done pulse ever follows.
- PUSH: op=001, wdata=0xDEADBEEF, zero-wait ack → cycle 2: mem_addr=1023, mem_we=1, mem_wdata=0xDEADBEEF; cycle 3: done=1, err=0; cycle 4: sp=1023.
- POP with 2 wait cycles: mem_rdata=0xDEADBEEF → done in cycle 5; rdata=0xDEADBEEF; reg_we=1 for one cycle; sp returns to 1024.
- CALL then RET:
  - CALL with wdata=0x40, target=0x100 → writes 0x40 to address 1023; pc_load=1, pc_next=0x100.
  - RET → reads address 1023; pc_next=0x40; sp=1024.
- Bounds:
  - POP at sp=1024 → cycle 2: done=1, err=1; no mem_req; sp unchanged.
  - With SP_INIT=2, SP_LIMIT=0: two PUSHes succeed; the third gives err=1 and sp stays 0.
- Illegal op and busy: op=000 and op=101 → err=1 with no memory access. A start pulsed during MEM is ignored; exactly one done is seen.
